// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Line / address geometry of the cache clients (icache line = 128 bits).
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 16;
  localparam int MAX_REQ    = 8;
  localparam int REQ_IDX_W  = $clog2(MAX_REQ);

  typedef struct packed {
    logic                  rw;
    logic [MEM_ADDR_W-1:0] addr;
    logic [LINE_W-1:0]     wdata;
    logic [REQ_IDX_W-1:0]  idx;
  } mem_txn_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client-side request/response bus plus the backing-memory port.
// slave: the arbiter; master: the clients and the memory model.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = LINE_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;
  logic                      resp_err;
  logic                      mem_valid;
  logic                      mem_rw;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_ready;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_grant, resp_valid, resp_rdata, resp_err,
           mem_valid, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_grant, resp_valid, resp_rdata, resp_err,
           mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational priority picker with a rotating base: the search starts
// at base_i and wraps. base_i = 0 degenerates to fixed lowest-index-wins.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   base_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // First asserted request at or after base_i, modulo NUM_REQ.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] c;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = IDX_W'((int'(base_i) + i) % NUM_REQ);
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// N-requester arbiter sharing one backing-memory port; one transaction
// in flight, fixed or round-robin selection, response-timeout watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = LINE_W,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT  = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_arr;
  assign addr_arr  = bus.req_addr;
  assign wdata_arr = bus.req_wdata;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               rw_q,    rw_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               err_q,   err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic [IDX_W-1:0]   base;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt_inc;

  assign base    = (ARB_MODE == ARB_RR) ? ptr_q : '0;
  assign cnt_inc = cnt_q + CNT_W'(1);

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i  (bus.req_valid),
    .base_i (base),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state: grant in IDLE, spend the grant cycle before BUSY so the
  // memory request starts one cycle after req_grant; mem_ready beats timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        if (|grant_q) begin
          state_d = BUSY;
        end else if (pick_any) begin
          grant_d = pick_gnt;
          rw_d    = bus.req_rw[pick_idx];
          addr_d  = addr_arr[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          idx_d   = pick_idx;
          cnt_d   = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          if (!rw_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          // Counter parks at TIMEOUT until the next grant clears it.
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched transaction registers; rst aborts anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      grant_q <= grant_d;
    end
  end

  assign bus.req_grant  = grant_q;
  assign bus.mem_valid  = (state_q == BUSY);
  assign bus.mem_rw     = (state_q == BUSY) & rw_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.resp_valid = (state_q == RESP) ? (NUM_REQ'(1) << idx_q) : '0;
  assign bus.resp_err   = (state_q == RESP) & err_q;
  assign bus.resp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter driven by the
// same stimulus in lockstep, each against its own small memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   rv, rw;
  logic [15:0]  a0, a1;
  logic [127:0] w0, w1;
  logic         mrdy;
  int           n_chk = 0;
  int           n_bad = 0;

  localparam logic [127:0] PAT_A = {8{16'hAAAA}};
  localparam logic [127:0] PAT_5 = {8{16'h5555}};
  localparam logic [127:0] PAT_W = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(128)) fx_if ();
  mem_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(128)) rr_if ();

  function automatic logic [127:0] mem_model(input logic [15:0] a);
    if (a == 16'h0040) return PAT_A;
    if (a == 16'h0080) return PAT_5;
    return {8{a}};
  endfunction

  assign fx_if.req_valid = rv;
  assign fx_if.req_rw    = rw;
  assign fx_if.req_addr  = {a1, a0};
  assign fx_if.req_wdata = {w1, w0};
  assign fx_if.mem_ready = mrdy;
  assign fx_if.mem_rdata = mem_model(fx_if.mem_addr);
  assign rr_if.req_valid = rv;
  assign rr_if.req_rw    = rw;
  assign rr_if.req_addr  = {a1, a0};
  assign rr_if.req_wdata = {w1, w0};
  assign rr_if.mem_ready = mrdy;
  assign rr_if.mem_rdata = mem_model(rr_if.mem_addr);

  mem_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(128), .ARB_MODE(ARB_FIXED), .TIMEOUT(4))
    u_fx (.clk(clk), .rst(rst), .bus(fx_if.slave));
  mem_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(128), .ARB_MODE(ARB_RR), .TIMEOUT(4))
    u_rr (.clk(clk), .rst(rst), .bus(rr_if.slave));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rv = 2'b11; rw = 2'b00; a0 = 16'h0040; a1 = 16'h0080;
    w0 = '0; w1 = '0; mrdy = 1'b0;

    // Reset held with both requesting: everything quiet.
    repeat (3) step();
    chk("rst_fx_ctl", {fx_if.req_grant, fx_if.resp_valid, fx_if.resp_err, fx_if.mem_valid, fx_if.mem_rw}, '0);
    chk("rst_rr_ctl", {rr_if.req_grant, rr_if.resp_valid, rr_if.resp_err, rr_if.mem_valid, rr_if.mem_rw}, '0);
    chk("rst_addr", {fx_if.mem_addr, rr_if.mem_addr}, '0);
    chk("rst_wdata", fx_if.mem_wdata | rr_if.mem_wdata, '0);
    chk("rst_rdata", fx_if.resp_rdata | rr_if.resp_rdata, '0);
    rst = 1'b0;
    step();
    chk("rel_fx_gnt", fx_if.req_grant, 2'b01);
    chk("rel_rr_gnt", rr_if.req_grant, 2'b01);

    // Both requesting continuously, two wait cycles per access.
    for (int t = 0; t < 3; t++) begin
      chk("cont_fx_gnt", fx_if.req_grant, 2'b01);
      chk("cont_rr_gnt", rr_if.req_grant, (t % 2 == 0) ? 2'b01 : 2'b10);
      step();                                  // B1
      chk("cont_mvalid", fx_if.mem_valid & rr_if.mem_valid, 1'b1);
      chk("cont_rr_addr", rr_if.mem_addr, (t % 2 == 0) ? 16'h0040 : 16'h0080);
      step();                                  // B2
      step(); mrdy = 1'b1;                     // B3
      step(); mrdy = 1'b0;                     // RESP
      if (t == 2) rv = 2'b00;
      chk("cont_fx_resp", fx_if.resp_valid, 2'b01);
      chk("cont_fx_rdata", fx_if.resp_rdata, PAT_A);
      chk("cont_rr_resp", rr_if.resp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
      chk("cont_rr_rdata", rr_if.resp_rdata, (t % 2 == 0) ? PAT_A : PAT_5);
      chk("cont_err", fx_if.resp_err | rr_if.resp_err, 1'b0);
      step();                                  // IDLE
      chk("cont_idle_resp", fx_if.resp_valid | rr_if.resp_valid, 2'b00);
      if (t < 2) step();                       // next grant
    end

    // Write from requester 1, zero wait states.
    rv = 2'b10; rw = 2'b10; a1 = 16'h0123; w1 = PAT_W;
    step();
    chk("wr_fx_gnt", fx_if.req_grant, 2'b10);
    chk("wr_rr_gnt", rr_if.req_grant, 2'b10);
    rv = 2'b00;
    step(); mrdy = 1'b1;
    chk("wr_rw", fx_if.mem_rw & rr_if.mem_rw, 1'b1);
    chk("wr_addr", fx_if.mem_addr, 16'h0123);
    chk("wr_wdata", rr_if.mem_wdata, PAT_W);
    step(); mrdy = 1'b0;
    chk("wr_fx_resp", fx_if.resp_valid, 2'b10);
    chk("wr_rr_resp", rr_if.resp_valid, 2'b10);
    chk("wr_rdata", fx_if.resp_rdata | rr_if.resp_rdata, '0);
    step();
    rw = 2'b00;

    // Timeout with a late mem_ready that must be ignored.
    rv = 2'b01; a0 = 16'h0040;
    step();
    chk("to_gnt", fx_if.req_grant, 2'b01);
    rv = 2'b00;
    repeat (4) step();
    chk("to_b4_mvalid", fx_if.mem_valid, 1'b1);
    step();
    chk("to_resp", fx_if.resp_valid, 2'b01);
    chk("to_err", fx_if.resp_err & rr_if.resp_err, 1'b1);
    chk("to_rdata", fx_if.resp_rdata, '0);
    chk("to_mvalid", fx_if.mem_valid, 1'b0);
    mrdy = 1'b1;
    step();
    chk("late_resp", fx_if.resp_valid | rr_if.resp_valid, 2'b00);
    chk("late_mvalid", fx_if.mem_valid, 1'b0);
    step();
    chk("late_resp2", {fx_if.resp_valid, fx_if.resp_err}, 3'b000);
    mrdy = 1'b0;

    // Normal access after the timeout.
    rv = 2'b01;
    step(); rv = 2'b00;
    step(); mrdy = 1'b1;
    step(); mrdy = 1'b0;
    chk("post_resp", fx_if.resp_valid, 2'b01);
    chk("post_err", fx_if.resp_err, 1'b0);
    chk("post_rdata", fx_if.resp_rdata, PAT_A);
    step();

    // mem_ready in the same cycle the counter reaches TIMEOUT: no error.
    rv = 2'b01; a0 = 16'h0080;
    step(); rv = 2'b00;
    step(); step(); step();
    step(); mrdy = 1'b1;                       // B4
    step(); mrdy = 1'b0;
    chk("edge_resp", rr_if.resp_valid, 2'b01);
    chk("edge_err", fx_if.resp_err | rr_if.resp_err, 1'b0);
    chk("edge_rdata", rr_if.resp_rdata, PAT_5);
    step();

    // Reset pulsed in the 2nd BUSY cycle; rr pointer was 1 beforehand.
    rv = 2'b01; a0 = 16'h0040;
    step(); rv = 2'b00;
    step(); step();
    rst = 1'b1; rv = 2'b11;
    step();
    rst = 1'b0;
    chk("abort_mvalid", fx_if.mem_valid | rr_if.mem_valid, 1'b0);
    chk("abort_resp", fx_if.resp_valid | rr_if.resp_valid, 2'b00);
    step();
    chk("abort_rr_gnt", rr_if.req_grant, 2'b01);
    chk("abort_fx_gnt", fx_if.req_grant, 2'b01);
    chk("abort_noresp", fx_if.resp_valid | rr_if.resp_valid, 2'b00);
    rv = 2'b00;
    step(); mrdy = 1'b1;
    step(); mrdy = 1'b0;
    chk("abort_next_resp", rr_if.resp_valid, 2'b01);
    chk("abort_next_rdata", rr_if.resp_rdata, PAT_A);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-requester arbiter that shares one backing-memory port among the pipeline's memory clients. The clients are the icache fill path, the dcache fill/writeback path, and any future clients. It replaces the point-to-point IF-to-MEM request wiring with a generalised arbiter. It offers selectable fixed-priority or round-robin arbitration, one outstanding transaction, and a response-timeout watchdog. It sits between the cache controllers and the memory model, below the top-level pipeline.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 128, data width (one cache line)
- ARB_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- TIMEOUT, 255, max cycles spent waiting on mem_ready before an error (1..2^16-1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_rw  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_grant  out  NUM_REQ  one-hot; pulses for 1 cycle when the request is accepted
- resp_valid  out  NUM_REQ  one-hot; 1-cycle completion pulse
- resp_rdata  out  DATA_W  read data; valid while resp_valid is asserted
- resp_err  out  1  asserted with resp_valid when the transaction timed out
- mem_valid  out  1  memory request
- mem_rw  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory completes the transaction this cycle
- mem_rdata  in  DATA_W  read data; sampled when mem_ready is asserted

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req_valid bit is set, select a winner, pulse req_grant[w], latch rw/addr/wdata/index, and go to BUSY. Otherwise stay in IDLE.
- BUSY:
  - mem_valid=1, driven from the latched fields; outputs are held stable until completion.
  - mem_ready=1: latch mem_rdata (reads only; writes latch nothing), go to RESP.
  - The timeout counter increments each BUSY cycle that mem_ready=0. When the counter reaches TIMEOUT, set the error bit, go to RESP, drop mem_valid, and discard any later mem_ready.
- RESP: pulse resp_valid[w] and resp_err (if set), drive resp_rdata, then return to IDLE.
- Fixed mode: the lowest asserted index wins.
- Round-robin mode:
  - A pointer holds the index after the last winner, and the search starts from the pointer with wrap-around.
  - The pointer updates only on grant.
  - The pointer resets to 0.
- A requester holds req_valid and its fields stable until req_grant. After the grant it drops req_valid, or keeps it asserted to queue a new request. A request still asserted in IDLE is re-arbitrated as new.
- The arbiter never grants while in BUSY or RESP, which gives a single outstanding transaction.
- Write response: resp_rdata=0.
- Timeout response: resp_rdata=0, resp_err=1.

## Timing
- Reset values:
  - state IDLE; rr pointer 0; timeout counter 0
  - req_grant, resp_valid, resp_err, mem_valid, mem_rw all 0
  - mem_addr, mem_wdata, resp_rdata all 0
- req_grant and the move to BUSY are registered, so req_grant is asserted the cycle after req_valid is first sampled in IDLE.
- mem_valid is first asserted in the cycle after req_grant.
- A mem_ready with zero wait state (seen in the first BUSY cycle) gives resp_valid one cycle later. Best-case request-to-response latency is 3 cycles.
- Back-to-back: the cycle after RESP is IDLE, so a new grant follows 1 cycle later. Peak throughput is one transaction per 4 cycles.
- mem_ready outside BUSY is ignored.
- If mem_ready arrives in the same cycle the counter reaches TIMEOUT, mem_ready wins and no error is reported.
- rst asserted mid-transaction:
  - Abort immediately and deassert mem_valid the next cycle.
  - No resp_valid is issued for the aborted request.
- Counter width is clog2(TIMEOUT+1). The counter saturates and clears on entering BUSY.

## Structure
- Add mem_arb_pkg, containing:
  - an arb_state_t enum (IDLE, BUSY, RESP)
  - ARB_FIXED/ARB_RR localparams
  - a mem_txn_t struct {rw, addr, wdata, idx} parametrised via package localparams that match icache_def line width
- Add one sub-module, rr_picker. It is a combinational NUM_REQ-wide priority selector with rotating base (base=0 gives fixed priority). It is shared with any future bus arbiters.

## Test plan
- Reset: hold rst 3 cycles with req_valid=2'b11 -> all outputs 0 and no grant; after release, req_grant=2'b01 one cycle later.
- Fixed mode, both requesting continuously, mem_ready after 2 wait cycles -> requester 0 is served each time and requester 1 is never granted.
- Round-robin, both requesting continuously, read addr 0x0040/0x0080, mem_rdata=0xAAAA…/0x5555… -> grants alternate 01,10,01; each resp_rdata matches its requester.
- Write from requester 1 with zero-wait mem_ready -> mem_rw=1, mem_addr/mem_wdata equal the latched values; resp_valid=2'b10 three cycles after req_valid; resp_rdata=0.
- TIMEOUT=4, mem_ready held 0 -> after 4 BUSY cycles resp_valid with resp_err=1; a mem_ready that arrives late is ignored; the next request completes normally with resp_err=0.
- rst pulsed in the 2nd BUSY cycle -> mem_valid=0 the next cycle, no resp_valid, rr pointer back to 0.
